// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback source select, load lane extraction
// and misaligned-load detection. Outputs are decoded from the WB registers.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_m2r_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_dm_out,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [DATA_W-1:0] in_hilo,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign_err
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  localparam logic [1:0] M2R_ALU     = 2'b00;
  localparam logic [1:0] M2R_MEM     = 2'b01;
  localparam logic [1:0] M2R_PCPLUS4 = 2'b10;
  localparam logic [1:0] M2R_HILO    = 2'b11;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;

  logic              valid_q;
  logic [1:0]        m2r_sel_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] dm_out_q;
  logic [DATA_W-1:0] pc_plus4_q;
  logic [DATA_W-1:0] hilo_q;
  logic [1:0]        ld_size_q;
  logic              ld_unsigned_q;
  logic              reg_write_q;
  logic [REG_AW-1:0] rd_q;

  // Priority: reset, then flush (bubble), then stall (hold), else load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      m2r_sel_q     <= '0;
      alu_result_q  <= '0;
      dm_out_q      <= '0;
      pc_plus4_q    <= '0;
      hilo_q        <= '0;
      ld_size_q     <= '0;
      ld_unsigned_q <= 1'b0;
      reg_write_q   <= 1'b0;
      rd_q          <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall) begin
      valid_q       <= in_valid;
      m2r_sel_q     <= in_m2r_sel;
      alu_result_q  <= in_alu_result;
      dm_out_q      <= in_dm_out;
      pc_plus4_q    <= in_pc_plus4;
      hilo_q        <= in_hilo;
      ld_size_q     <= in_ld_size;
      ld_unsigned_q <= in_ld_unsigned;
      reg_write_q   <= in_reg_write;
      rd_q          <= in_rd;
    end
  end

  logic [OFF_W-1:0] off;
  logic [1:0]       eff_size;
  logic [31:0]      lane_bits;
  logic [31:0]      word_lane;
  logic [DATA_W-1:0] load_val;
  logic             misaligned;

  assign off = alu_result_q[OFF_W-1:0];
  // A dword request on a 32-bit datapath behaves as a word load.
  assign eff_size  = (DATA_W == 32 && ld_size_q == 2'b11) ? LD_W : ld_size_q;
  assign lane_bits = 32'(dm_out_q >> {off, 3'b000});
  assign word_lane = (DATA_W == 32) ? dm_out_q[31:0] : lane_bits;

  // Lane extraction with sign or zero extension.
  always_comb begin
    load_val = '0;
    case (eff_size)
      LD_B: begin
        if (ld_unsigned_q) load_val = DATA_W'(lane_bits[7:0]);
        else               load_val = DATA_W'($signed(lane_bits[7:0]));
      end
      LD_H: begin
        if (ld_unsigned_q) load_val = DATA_W'(lane_bits[15:0]);
        else               load_val = DATA_W'($signed(lane_bits[15:0]));
      end
      LD_W: begin
        if (ld_unsigned_q) load_val = DATA_W'(word_lane);
        else               load_val = DATA_W'($signed(word_lane));
      end
      default: load_val = dm_out_q;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (eff_size)
      LD_B:    misaligned = 1'b0;
      LD_H:    misaligned = (off & OFF_W'(1)) != '0;
      LD_W:    misaligned = (off & OFF_W'(3)) != '0;
      default: misaligned = (off & OFF_W'(7)) != '0;
    endcase
  end

  always_comb begin
    wb_data = alu_result_q;
    case (m2r_sel_q)
      M2R_ALU:     wb_data = alu_result_q;
      M2R_MEM:     wb_data = load_val;
      M2R_PCPLUS4: wb_data = pc_plus4_q;
      M2R_HILO:    wb_data = hilo_q;
      default:     wb_data = alu_result_q;
    endcase
  end

  assign misalign_err = valid_q & (m2r_sel_q == M2R_MEM) & misaligned;
  assign wb_valid     = valid_q;
  assign wb_rd        = rd_q;
  // r0 is hardwired, so a write to it is suppressed.
  assign wb_reg_write = valid_q & reg_write_q & ~misalign_err & (rd_q != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: 32- and 64-bit instances share stimulus and are
// checked against a transaction-level model of the WB stage contents.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid, in_ld_unsigned, in_reg_write;
  logic [1:0]  in_m2r_sel, in_ld_size;
  logic [63:0] in_alu, in_dm, in_pc, in_hilo;
  logic [4:0]  in_rd;

  logic        v32, rw32, mis32, v64, rw64, mis64;
  logic [4:0]  rd32, rd64;
  logic [31:0] d32;
  logic [63:0] d64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_m2r_sel(in_m2r_sel),
    .in_alu_result(in_alu[31:0]), .in_dm_out(in_dm[31:0]),
    .in_pc_plus4(in_pc[31:0]), .in_hilo(in_hilo[31:0]),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .in_reg_write(in_reg_write), .in_rd(in_rd),
    .wb_valid(v32), .wb_reg_write(rw32), .wb_rd(rd32), .wb_data(d32),
    .misalign_err(mis32)
  );

  mem_wb_stage #(.DATA_W(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_m2r_sel(in_m2r_sel),
    .in_alu_result(in_alu), .in_dm_out(in_dm),
    .in_pc_plus4(in_pc), .in_hilo(in_hilo),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .in_reg_write(in_reg_write), .in_rd(in_rd),
    .wb_valid(v64), .wb_reg_write(rw64), .wb_rd(rd64), .wb_data(d64),
    .misalign_err(mis64)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  sel;
    logic [63:0] alu, dm, pc, hilo;
    logic [1:0]  sz;
    logic        u;
    logic        rw;
    logic [4:0]  rd;
  } txn_t;

  txn_t wb_m;

  function automatic logic [63:0] mask_w(input int w, input logic [63:0] x);
    return (w == 32) ? {32'h0, x[31:0]} : x;
  endfunction

  // Expected outputs of a width-w stage holding transaction t.
  function automatic void model_out(input txn_t t, input int w,
                                    output logic ev, output logic erw,
                                    output logic emis, output logic [4:0] erd,
                                    output logic [63:0] ed);
    int nb;
    int off;
    logic [63:0] dmw, lane, lmask;
    dmw = mask_w(w, t.dm);
    off = int'(t.alu[2:0]) % (w / 8);
    case (t.sz)
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = (w == 64) ? 8 : 4;
    endcase
    if (nb * 8 == w) begin
      lane = dmw;
    end else begin
      lmask = (64'd1 << (8 * nb)) - 64'd1;
      lane = (dmw >> (8 * off)) & lmask;
      if (!t.u && lane[8*nb-1]) lane = lane | ~lmask;
    end
    lane = mask_w(w, lane);
    emis = t.valid && (t.sel == 2'd1) && ((off % nb) != 0);
    case (t.sel)
      2'd0:    ed = mask_w(w, t.alu);
      2'd1:    ed = lane;
      2'd2:    ed = mask_w(w, t.pc);
      default: ed = mask_w(w, t.hilo);
    endcase
    ev  = t.valid;
    erd = t.rd;
    erw = t.valid && t.rw && !emis && (t.rd != 5'd0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic ev, erw, emis;
    logic [4:0] erd;
    logic [63:0] ed;
    model_out(wb_m, 32, ev, erw, emis, erd, ed);
    chk({tag, "/v32"},   64'(v32),   64'(ev));
    chk({tag, "/rw32"},  64'(rw32),  64'(erw));
    chk({tag, "/mis32"}, 64'(mis32), 64'(emis));
    chk({tag, "/rd32"},  64'(rd32),  64'(erd));
    chk({tag, "/d32"},   64'(d32),   ed);
    model_out(wb_m, 64, ev, erw, emis, erd, ed);
    chk({tag, "/v64"},   64'(v64),   64'(ev));
    chk({tag, "/rw64"},  64'(rw64),  64'(erw));
    chk({tag, "/mis64"}, 64'(mis64), 64'(emis));
    chk({tag, "/rd64"},  64'(rd64),  64'(erd));
    chk({tag, "/d64"},   d64,        ed);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [63:0] a,
                       input logic [63:0] d, input logic [63:0] p, input logic [63:0] h,
                       input logic [1:0] z, input logic uu, input logic w,
                       input logic [4:0] r);
    in_valid = v; in_m2r_sel = s; in_alu = a; in_dm = d; in_pc = p; in_hilo = h;
    in_ld_size = z; in_ld_unsigned = uu; in_reg_write = w; in_rd = r;
  endtask

  // One clock edge with the given controls; model updates, then compare.
  task automatic tick(input string tag, input logic st, input logic fl, input logic rs);
    stall = st; flush = fl; rst = rs;
    @(posedge clk);
    if (rs) begin
      wb_m = '{valid: 1'b0, sel: 2'b0, alu: 64'h0, dm: 64'h0, pc: 64'h0,
               hilo: 64'h0, sz: 2'b0, u: 1'b0, rw: 1'b0, rd: 5'h0};
    end else if (fl) begin
      wb_m.valid = 1'b0;
      wb_m.rw    = 1'b0;
    end else if (!st) begin
      wb_m = '{valid: in_valid, sel: in_m2r_sel, alu: in_alu, dm: in_dm, pc: in_pc,
               hilo: in_hilo, sz: in_ld_size, u: in_ld_unsigned, rw: in_reg_write,
               rd: in_rd};
    end
    #1;
    check_all(tag);
  endtask

  localparam logic [63:0] DM = 64'h0000_0000_80FF_7F01;

  initial begin
    stall = 1'b0; flush = 1'b0; rst = 1'b1;
    drive(1, 2'd0, 64'hFFFF_1234_5678_9ABC, DM, 64'h44, 64'h55, 2'd2, 0, 1, 5'd7);
    wb_m = '{valid: 1'b0, sel: 2'b0, alu: 64'h0, dm: 64'h0, pc: 64'h0,
             hilo: 64'h0, sz: 2'b0, u: 1'b0, rw: 1'b0, rd: 5'h0};

    tick("rst0", 0, 0, 1);
    tick("rst1", 0, 0, 1);
    chk("rst_v", 64'(v32), 64'd0);
    chk("rst_rw", 64'(rw32), 64'd0);
    chk("rst_d", 64'(d32), 64'd0);
    chk("rst_d64", d64, 64'd0);
    tick("release", 0, 0, 0);
    chk("release_rd", 64'(rd32), 64'd7);

    drive(1, 2'd0, 64'h1234_5678, DM, 64'h0, 64'h0, 2'd2, 0, 1, 5'd8);
    tick("alu", 0, 0, 0);
    chk("alu_d", 64'(d32), 64'h1234_5678);
    chk("alu_rw", 64'(rw32), 64'd1);
    drive(1, 2'd2, 64'h0, DM, 64'h0040_0010, 64'h0, 2'd2, 0, 1, 5'd31);
    tick("jal", 0, 0, 0);
    chk("jal_d", 64'(d32), 64'h0040_0010);
    drive(1, 2'd3, 64'h0, DM, 64'h0, 64'hDEAD_BEEF, 2'd2, 0, 1, 5'd9);
    tick("hilo", 0, 0, 0);
    chk("hilo_d", 64'(d32), 64'hDEAD_BEEF);

    drive(1, 2'd1, 64'h1003, DM, 0, 0, 2'd0, 0, 1, 5'd2); tick("lb", 0, 0, 0);
    chk("lb_d", 64'(d32), 64'hFFFF_FF80);
    drive(1, 2'd1, 64'h1003, DM, 0, 0, 2'd0, 1, 1, 5'd2); tick("lbu", 0, 0, 0);
    chk("lbu_d", 64'(d32), 64'h0000_0080);
    drive(1, 2'd1, 64'h1002, DM, 0, 0, 2'd1, 0, 1, 5'd2); tick("lh", 0, 0, 0);
    chk("lh_d", 64'(d32), 64'hFFFF_80FF);
    drive(1, 2'd1, 64'h1000, DM, 0, 0, 2'd1, 1, 1, 5'd2); tick("lhu", 0, 0, 0);
    chk("lhu_d", 64'(d32), 64'h0000_7F01);
    drive(1, 2'd1, 64'h1000, DM, 0, 0, 2'd2, 0, 1, 5'd2); tick("lw", 0, 0, 0);
    chk("lw_d", 64'(d32), 64'h80FF_7F01);

    drive(1, 2'd1, 64'h1001, DM, 0, 0, 2'd1, 0, 1, 5'd3); tick("lh_mis", 0, 0, 0);
    chk("lh_mis_err", 64'(mis32), 64'd1);
    chk("lh_mis_rw", 64'(rw32), 64'd0);
    chk("lh_mis_v", 64'(v32), 64'd1);
    tick("mis_stall", 1, 0, 0);
    chk("mis_stall_err", 64'(mis32), 64'd1);
    drive(1, 2'd1, 64'h1002, DM, 0, 0, 2'd2, 0, 1, 5'd3); tick("lw_mis", 0, 0, 0);
    chk("lw_mis_err", 64'(mis32), 64'd1);
    drive(1, 2'd1, 64'h1000, DM, 0, 0, 2'd2, 0, 1, 5'd3); tick("lw_ok", 0, 0, 0);
    chk("lw_ok_err", 64'(mis32), 64'd0);

    drive(1, 2'd0, 64'hA5A5_A5A5, DM, 0, 0, 2'd2, 0, 1, 5'd4); tick("stA", 0, 0, 0);
    drive(1, 2'd0, 64'h5A5A_5A5A, DM, 0, 0, 2'd2, 0, 1, 5'd5);
    for (int i = 0; i < 3; i++) begin
      tick("stall", 1, 0, 0);
      chk("stall_hold", 64'(d32), 64'hA5A5_A5A5);
    end
    tick("stB", 0, 0, 0);
    chk("stall_next", 64'(d32), 64'h5A5A_5A5A);
    tick("flush_stall", 1, 1, 0);
    chk("fs_v", 64'(v32), 64'd0);
    chk("fs_rw", 64'(rw32), 64'd0);
    drive(1, 2'd0, 64'h77, DM, 0, 0, 2'd2, 0, 1, 5'd0); tick("r0", 0, 0, 0);
    chk("r0_rw", 64'(rw32), 64'd0);

    drive(1, 2'd1, 64'h2000, 64'h8000_0001_1234_5678, 0, 0, 2'd3, 0, 1, 5'd6);
    tick("ld", 0, 0, 0);
    chk("ld_d64", d64, 64'h8000_0001_1234_5678);
    drive(1, 2'd1, 64'h2004, 64'h8000_0001_1234_5678, 0, 0, 2'd2, 0, 1, 5'd6);
    tick("lw64", 0, 0, 0);
    chk("lw64_d", d64, 64'hFFFF_FFFF_8000_0001);
    drive(1, 2'd1, 64'h2004, 64'h8000_0001_1234_5678, 0, 0, 2'd3, 0, 1, 5'd6);
    tick("ld_mis", 0, 0, 0);
    chk("ld_mis_err", 64'(mis64), 64'd1);
    tick("rst_in_stall", 1, 0, 1);
    chk("rst_stall_v", 64'(v64), 64'd0);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom));
      tick("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline register combined with the writeback source selector.
- Latches MEM-stage results at the clock edge.
- Selects one of four writeback sources: ALU, data memory, PC+4 or HI/LO.
- For memory loads, extracts the byte, half or word from the data-memory word and sign- or zero-extends it.
- Drives the register-file write port and the WB forwarding path.
- Supports stall, flush and misaligned-load detection, which the plain writeback mux does not have.

Parameters:
- DATA_W, 32, datapath width; legal values are 32 or 64.
- REG_AW, 5, register-file address width.
- OFF_W, derived as log2(DATA_W/8) (2 for 32, 3 for 64), byte-offset width. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold the WB registers.
- flush  input  1  load a bubble into WB.
- in_valid  input  1  the MEM-stage instruction is valid.
- in_m2r_sel  input  2  writeback source: 00=M2R_ALU, 01=M2R_MEM, 10=M2R_PCPLUS4, 11=M2R_HILO (new code, added to ctrl_encode_def.v).
- in_alu_result  input  DATA_W  ALU result. For loads this is the effective address.
- in_dm_out  input  DATA_W  aligned data-memory word.
- in_pc_plus4  input  DATA_W  return address.
- in_hilo  input  DATA_W  HI/LO read value.
- in_ld_size  input  2  load size: 00 byte, 01 half, 10 word, 11 dword.
- in_ld_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- in_reg_write  input  1  the instruction writes the register file.
- in_rd  input  REG_AW  destination register.
- wb_valid  output  1  WB stage holds a valid instruction.
- wb_reg_write  output  1  register-file write enable.
- wb_rd  output  REG_AW  register-file write address.
- wb_data  output  DATA_W  register-file write data, also driven to the forwarding path.
- misalign_err  output  1  the instruction in WB is a misaligned load.

Behaviour:
- Registered fields are loaded from the in_* ports: valid, m2r_sel, alu_result, dm_out, pc_plus4, hilo, ld_size, ld_unsigned, reg_write, rd.
- Register update priority at each rising clk edge:
  - rst: all registers cleared to 0.
  - else flush: valid and reg_write cleared to 0; other fields don't-care.
  - else stall: all registers hold.
  - else: all registers load from the in_* ports.
- Flush and stall asserted together: flush wins and a bubble is inserted.
- Latency: one cycle from input to output. wb_* are combinational from the registered fields, with no extra register.
- Reset values: wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, misalign_err=0.
- Source selection (wb_data):
  - ALU selects alu_result.
  - PCPLUS4 selects pc_plus4.
  - HILO selects hilo.
  - MEM selects the extracted load value.
  - Every case drives a value; no latch is permitted.
- Load extraction (little-endian lanes). Let off = alu_result[OFF_W-1:0].
  - byte: lane dm_out[8*off+7 : 8*off].
  - half: lane dm_out[8*off+15 : 8*off].
  - word: lane dm_out[8*off+31 : 8*off].
  - dword: all of dm_out. Only legal when DATA_W=64; with DATA_W=32, ld_size=11 is treated as word.
  - With DATA_W=32, word is the full dm_out.
  - Extension fills the remaining upper bits up to DATA_W with 0 if ld_unsigned=1, otherwise with the lane MSB.
- Misalignment, evaluated only when valid=1 and m2r_sel=MEM:
  - half is misaligned when off[0]=1.
  - word is misaligned when off[1:0]!=0.
  - dword is misaligned when off[2:0]!=0.
  - byte is never misaligned.
- misalign_err = valid & is_mem & misaligned. It is asserted for each cycle the instruction sits in WB, including stalled cycles.
- wb_reg_write = valid & reg_write & ~misalign_err & (rd != 0). A write to r0 is never issued.
- wb_valid = valid. wb_rd = rd.
- When misaligned, wb_data still shows the extracted value, but no write occurs.
- Reset asserted during a stall clears the stage. It takes priority over stall and flush.

Test Plan:
- Reset: hold rst for 2 cycles with non-zero inputs -> all outputs 0. After release with stall=0, inputs appear on the next edge.
- ALU / JAL / HILO paths: sel=00, alu_result=0x1234_5678, rd=8 -> next cycle wb_data=0x12345678, wb_reg_write=1. sel=10, pc_plus4=0x0040_0010, rd=31 -> wb_data=0x00400010. sel=11, hilo=0xDEAD_BEEF -> wb_data=0xDEADBEEF.
- Loads, dm_out=0x80FF_7F01 (DATA_W=32):
  - lb, addr 0x...3 -> 0xFFFFFF80.
  - lbu, addr 0x...3 -> 0x00000080.
  - lh, addr 0x...2 -> 0xFFFF80FF.
  - lhu, addr 0x...0 -> 0x00007F01.
  - lw, addr 0x...0 -> 0x80FF7F01.
- Misaligned: lh at addr 0x...1, or lw at addr 0x...2 -> misalign_err=1, wb_reg_write=0, wb_valid=1. A following aligned lw -> misalign_err=0.
- Stall/flush: stall=1 for 3 cycles -> outputs frozen, no duplicate or lost instruction. Flush and stall together -> next cycle wb_valid=0, wb_reg_write=0. A write with rd=0 -> wb_reg_write=0.
- DATA_W=64 build: ld dword with addr 0x...0 -> full 64-bit value. lw with addr 0x...4, dm_out upper half 0x8000_0001 -> 0xFFFFFFFF_80000001. ld with addr 0x...4 -> misalign_err=1.
